// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for the WM8731 DAC path.
// Stereo frame words enter through a valid/ready handshake and wait in a
// single-entry buffer. Each channel is shifted out MSB-first on DAC_DAT.
// DAC_DAT changes on BCLK falling-edge strobes and follows DAC_LRC from the
// shared timing generator.
// Optional build macro I2S_TX_HOLD_LAST_EN: when defined, an underrun repeats
// the previous frame. When undefined, an underrun sends silence.
module i2s_tx #(
  parameter int DEPTH = 16
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        DAC_LRC,
  input  logic        i_p_bclk,
  input  logic        i_n_bclk,
  input  logic [31:0] i_tx_data,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic        DAC_DAT,
  output logic        o_underrun
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 r_buf_full;
  logic [2*DEPTH-1:0]   r_buf;
  logic [2*DEPTH-1:0]   r_frame_reg;
  logic                 r_lrc_q;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DEPTH-1:0]     r_shreg;

  logic                 w_accept;
  logic                 w_chan_start;
  logic                 w_left_start;
  logic                 w_right_start;
  logic [2*DEPTH-1:0]   w_in_word;
  logic [2*DEPTH-1:0]   w_next_frame;
  logic                 w_unused;

  // The P-edge strobe and the data bits outside the two channel fields are deliberately ignored.
  assign w_unused = ^{i_p_bclk, i_tx_data};

  assign o_tx_ready    = ~r_buf_full;
  assign w_accept      = i_tx_valid & ~r_buf_full;
  assign w_chan_start  = i_n_bclk & (DAC_LRC != r_lrc_q);
  // A falling LRC starts the left channel and therefore a new frame.
  assign w_left_start  = w_chan_start & ~DAC_LRC;
  assign w_right_start = w_chan_start & DAC_LRC;
  assign w_in_word     = {i_tx_data[16+DEPTH-1:16], i_tx_data[DEPTH-1:0]};

  // Pick the frame that the next left start will play: the buffered word, or the underrun fill.
  always_comb begin
    // NOTE: give every always_comb output a value before any branch, so that no latch is inferred.
    w_next_frame = '0;
    if (r_buf_full) begin
      w_next_frame = r_buf;
    end else begin
`ifdef I2S_TX_HOLD_LAST_EN
      w_next_frame = r_frame_reg;
`else
      w_next_frame = '0;
`endif
    end
  end

  // Single-entry buffer: filled on accept, emptied when a left start takes the word.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking (<=) so that every block sees pre-edge values.
      r_buf_full <= 1'b0;
      r_buf      <= '0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= w_in_word;
    end else if (w_left_start) begin
      r_buf_full <= 1'b0;
    end
  end

  // Track LRC at each BCLK falling edge so that channel boundaries can be detected.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_lrc_q <= 1'b1;
    end else if (i_n_bclk) begin
      r_lrc_q <= DAC_LRC;
    end
  end

  // Latch the frame at each left start, and flag an underrun when no word was waiting.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_frame_reg <= '0;
      o_underrun  <= 1'b0;
    end else begin
      o_underrun <= w_left_start & ~r_buf_full;
      if (w_left_start) begin
        r_frame_reg <= w_next_frame;
      end
    end
  end

  // Serialiser: output the current MSB, then shift, or reload at a channel start.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      DAC_DAT   <= 1'b0;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_n_bclk) begin
      DAC_DAT <= (r_bit_cnt != '0) ? r_shreg[DEPTH-1] : 1'b0;
      if (w_left_start) begin
        r_shreg   <= w_next_frame[2*DEPTH-1:DEPTH];
        r_bit_cnt <= CNT_W'(DEPTH);
      end else if (w_right_start) begin
        r_shreg   <= r_frame_reg[DEPTH-1:0];
        r_bit_cnt <= CNT_W'(DEPTH);
      end else begin
        r_shreg <= r_shreg << 1;
        if (r_bit_cnt != '0) begin
          r_bit_cnt <= r_bit_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx (DEPTH = 16).
// The bench contains its own BCLK/LRC generator, using 4 clk_50m cycles per BCLK.
// A reference model describes the serial line as a queue of pending bits.
// Each channel start replaces the queue with the new word's bits, MSB first.
// Each BCLK falling edge pops one bit, or gives 0 once the queue is empty.
// Build with +define+I2S_TX_HOLD_LAST_EN to check the hold-last variant.
module tb_i2s_tx;

  localparam int DEPTH = 16;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        rst;
  logic        DAC_LRC;
  logic        i_p_bclk;
  logic        i_n_bclk;
  logic [31:0] i_tx_data;
  logic        i_tx_valid;
  logic        o_tx_ready;
  logic        DAC_DAT;
  logic        o_underrun;

  i2s_tx #(.DEPTH(DEPTH)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .DAC_LRC   (DAC_LRC),
    .i_p_bclk  (i_p_bclk),
    .i_n_bclk  (i_n_bclk),
    .i_tx_data (i_tx_data),
    .i_tx_valid(i_tx_valid),
    .o_tx_ready(o_tx_ready),
    .DAC_DAT   (DAC_DAT),
    .o_underrun(o_underrun)
  );

  always #5 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;

  // Generator state
  int gen_sub;
  int gen_pos;
  int gen_l;
  int gen_l_next;
  bit rand_gate;
  logic [31:0] wr_q[$];

  // Reference model state
  bit          m_full;
  bit          m_lrc;
  bit          m_dat;
  bit          m_und;
  bit          m_acc;
  logic [31:0] m_buf;
  logic [31:0] m_frame;
  bit          m_q[$];

  // Observations
  logic obs_dat;
  logic obs_und;
  logic obs_rdy;
  int   ready_hi;
  bit   cap_bit [0:199];
  bit   cap_und [0:199];

  task automatic model_reset();
    m_full  = 1'b0;
    m_lrc   = 1'b1;
    m_dat   = 1'b0;
    m_und   = 1'b0;
    m_acc   = 1'b0;
    m_buf   = '0;
    m_frame = '0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit und;
    bit start;
    if (rst) begin
      model_reset();
    end else begin
      m_acc = i_tx_valid && !m_full;
      und   = 1'b0;
      if (i_n_bclk) begin
        start = (DAC_LRC != m_lrc);
        m_lrc = DAC_LRC;
        m_dat = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
        if (start) begin
          m_q.delete();
          if (!DAC_LRC) begin
            if (m_full) begin
              m_frame = m_buf;
              m_full  = 1'b0;
            end else begin
              if (!HOLD) m_frame = '0;
              und = 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) m_q.push_back(m_frame[16+DEPTH-1-i]);
          end else begin
            for (int i = 0; i < DEPTH; i++) m_q.push_back(m_frame[DEPTH-1-i]);
          end
        end
      end
      if (m_acc) begin
        m_full = 1'b1;
        m_buf  = i_tx_data;
      end
      m_und = und;
    end
  endtask

  // One clk_50m cycle: drive generator and writer, update model at the edge, compare #1 later.
  task automatic clk_cycle();
    i_n_bclk = (gen_sub == 0);
    i_p_bclk = (gen_sub == 2);
    if (gen_sub == 0) DAC_LRC = (gen_pos >= gen_l);
    if (!i_tx_valid && wr_q.size() > 0 && (!rand_gate || $urandom_range(0, 2) == 0)) begin
      i_tx_valid = 1'b1;
      i_tx_data  = wr_q[0];
    end
    @(posedge clk_50m);
    model_update();
    #1;
    obs_dat = DAC_DAT;
    obs_und = o_underrun;
    obs_rdy = o_tx_ready;
    if (obs_rdy === 1'b1) ready_hi++;
    checks++;
    if (obs_dat !== m_dat)
      begin errors++; $display("FAIL dac_dat t=%0t got %b exp %b", $time, obs_dat, m_dat); end
    checks++;
    if (obs_rdy !== !m_full)
      begin errors++; $display("FAIL tx_ready t=%0t got %b exp %b", $time, obs_rdy, !m_full); end
    checks++;
    if (obs_und !== m_und)
      begin errors++; $display("FAIL underrun t=%0t got %b exp %b", $time, obs_und, m_und); end
    if (m_acc) begin
      void'(wr_q.pop_front());
      i_tx_valid = 1'b0;
    end
    gen_sub++;
    if (gen_sub == 4) begin
      gen_sub = 0;
      gen_pos++;
      if (gen_pos == 2 * gen_l) begin
        gen_pos = 0;
        gen_l   = gen_l_next;
      end
    end
  endtask

  task automatic run_bclk(output bit b, output bit u);
    b = 1'b0;
    u = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clk_cycle();
      if (c == 0) begin
        b = obs_dat;
        u = obs_und;
      end
    end
  endtask

  // Run until the next BCLK is a left start.
  task automatic align_frame();
    bit b, u;
    int n = 0;
    while (gen_pos != 0 && n < 300) begin
      run_bclk(b, u);
      n++;
    end
    if (gen_pos != 0) begin
      errors++;
      $display("FAIL align_timeout got pos %0d exp 0", gen_pos);
    end
  endtask

  // Capture n frames starting at a left start, plus the following start edge.
  task automatic capture_frames(input int n);
    bit b, u;
    int total;
    total = n * 2 * gen_l + 1;
    for (int k = 0; k < total; k++) begin
      run_bclk(b, u);
      cap_bit[k] = b;
      cap_und[k] = u;
    end
  endtask

  function automatic logic [31:0] cap_word(input int base, input int l);
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w[31-i] = cap_bit[base+1+i];
      w[15-i] = cap_bit[base+l+1+i];
    end
    return w;
  endfunction

  task automatic test_reset();
    bit b, u;
    int ones = 0;
    rst = 1'b1; DAC_LRC = 1'b0; i_n_bclk = 1'b0; i_p_bclk = 1'b0;
    i_tx_valid = 1'b0; i_tx_data = '0;
    gen_sub = 0; gen_pos = 0; gen_l = 32; gen_l_next = 32; rand_gate = 1'b0;
    model_reset();
    #12;
    checks++;
    if (DAC_DAT !== 1'b0) begin errors++; $display("FAIL reset_dat got %b exp 0", DAC_DAT); end
    checks++;
    if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_tx_ready); end
    checks++;
    if (o_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", o_underrun); end
    run_bclk(b, u);
    run_bclk(b, u);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_bclk(b, u);
      if (b) ones++;
    end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL reset_quiet got %0d ones exp 0", ones); end
  endtask

  task automatic test_basic_frame();
    logic [31:0] w;
    int ones = 0;
    int unds = 0;
    wr_q.push_back(32'hA5A5_3C3C);
    align_frame();
    capture_frames(1);
    w = cap_word(0, 32);
    checks++;
    if (w[31:16] !== 16'hA5A5) begin errors++; $display("FAIL basic_left got %h exp a5a5", w[31:16]); end
    checks++;
    if (w[15:0] !== 16'h3C3C) begin errors++; $display("FAIL basic_right got %h exp 3c3c", w[15:0]); end
    for (int k = 17; k <= 32; k++) if (cap_bit[k]) ones++;
    for (int k = 49; k <= 64; k++) if (cap_bit[k]) ones++;
    for (int k = 0; k < 64; k++) if (cap_und[k]) unds++;
    checks++;
    if (ones != 0) begin errors++; $display("FAIL basic_tail_zero got %0d ones exp 0", ones); end
    checks++;
    if (unds != 0) begin errors++; $display("FAIL basic_no_underrun got %0d exp 0", unds); end
  endtask

  task automatic test_underrun();
    logic [31:0] w;
    logic [31:0] exp_w;
    int unds = 0;
    exp_w = HOLD ? 32'hA5A5_3C3C : 32'h0;
    align_frame();
    capture_frames(1);
    w = cap_word(0, 32);
    for (int k = 0; k < 64; k++) if (cap_und[k]) unds++;
    checks++;
    if (cap_und[0] !== 1'b1) begin errors++; $display("FAIL underrun_pulse got %b exp 1", cap_und[0]); end
    checks++;
    if (unds != 1) begin errors++; $display("FAIL underrun_count got %0d exp 1", unds); end
    checks++;
    if (w !== exp_w) begin errors++; $display("FAIL underrun_frame got %h exp %h", w, exp_w); end
  endtask

  task automatic test_collision();
    logic [31:0] c;
    logic [31:0] w0, w1;
    logic [31:0] exp0;
    c    = 32'h5A0F_C3E1;
    exp0 = HOLD ? 32'hA5A5_3C3C : 32'h0;
    align_frame();
    wr_q.push_back(c);
    capture_frames(2);
    w0 = cap_word(0, 32);
    w1 = cap_word(64, 32);
    checks++;
    if (cap_und[0] !== 1'b1) begin errors++; $display("FAIL collision_underrun got %b exp 1", cap_und[0]); end
    checks++;
    if (cap_und[64] !== 1'b0) begin errors++; $display("FAIL collision_next_underrun got %b exp 0", cap_und[64]); end
    checks++;
    if (w0 !== exp0) begin errors++; $display("FAIL collision_frame0 got %h exp %h", w0, exp0); end
    checks++;
    if (w1 !== c) begin errors++; $display("FAIL collision_frame1 got %h exp %h", w1, c); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] a, b_w;
    logic [31:0] w0, w1;
    bit b, u;
    a   = $urandom;
    b_w = $urandom;
    wr_q.push_back(a);
    wr_q.push_back(b_w);
    run_bclk(b, u);
    ready_hi = 0;
    align_frame();
    checks++;
    if (ready_hi != 0) begin errors++; $display("FAIL bp_ready_low got %0d high cycles exp 0", ready_hi); end
    capture_frames(2);
    w0 = cap_word(0, 32);
    w1 = cap_word(64, 32);
    checks++;
    if (w0 !== a) begin errors++; $display("FAIL bp_frame_a got %h exp %h", w0, a); end
    checks++;
    if (w1 !== b_w) begin errors++; $display("FAIL bp_frame_b got %h exp %h", w1, b_w); end
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL bp_drained got %0d exp 0", wr_q.size()); end
  endtask

  task automatic test_tight_channel();
    logic [31:0] w;
    logic [31:0] got;
    w = $urandom;
    gen_l_next = 16;
    wr_q.push_back(w);
    align_frame();
    capture_frames(1);
    got = cap_word(0, 16);
    checks++;
    if (got !== w) begin errors++; $display("FAIL tight_frame got %h exp %h", got, w); end
    checks++;
    if (cap_bit[16] !== w[16]) begin errors++; $display("FAIL tight_left_lsb got %b exp %b", cap_bit[16], w[16]); end
    checks++;
    if (cap_bit[17] !== w[15]) begin errors++; $display("FAIL tight_right_msb got %b exp %b", cap_bit[17], w[15]); end
    gen_l_next = 32;
  endtask

  task automatic test_reset_mid_frame();
    bit b, u;
    int ones = 0;
    wr_q.push_back(32'hA5A5_3C3C);
    align_frame();
    run_bclk(b, u);
    run_bclk(b, u);
    checks++;
    if (b !== 1'b1) begin errors++; $display("FAIL midrst_msb got %b exp 1", b); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (DAC_DAT !== 1'b0) begin errors++; $display("FAIL midrst_dat got %b exp 0", DAC_DAT); end
    checks++;
    if (o_tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", o_tx_ready); end
    checks++;
    if (o_underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got %b exp 0", o_underrun); end
    run_bclk(b, u);
    rst = 1'b0;
    while (gen_pos != 0) begin
      run_bclk(b, u);
      if (b) ones++;
    end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL midrst_quiet got %0d ones exp 0", ones); end
  endtask

  task automatic test_random();
    bit b, u;
    int lens[4] = '{12, 16, 20, 32};
    rand_gate = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (gen_pos == 1) gen_l_next = lens[$urandom_range(0, 3)];
      if (wr_q.size() < 2 && $urandom_range(0, 30) == 0) wr_q.push_back($urandom);
      run_bclk(b, u);
    end
    rand_gate = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_collision();
    test_back_pressure();
    test_tight_channel();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
